// File: rtl/dac_spi_pkg.sv
// Shared constants, FSM state type and frame builder for the shared SPI DAC arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dac_spi_pkg;

    localparam int FRAME_W  = 16;
    localparam int DATA_W   = 12;

    // Bit positions inside the 16-bit DAC write frame
    localparam int CH_BIT   = 15;
    localparam int BUF_BIT  = 14;
    localparam int GA_BIT   = 13;
    localparam int SHDN_BIT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Channel A, unbuffered; SHDN pin of the DAC is active-low, hence the inversion.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [DATA_W-1:0] data,
        input logic              gain,
        input logic              shutdown
    );
        logic [FRAME_W-1:0] frame;
        frame               = '0;
        frame[CH_BIT]       = 1'b0;
        frame[BUF_BIT]      = 1'b0;
        frame[GA_BIT]       = gain;
        frame[SHDN_BIT]     = ~shutdown;
        frame[DATA_W-1:0]   = data;
        return frame;
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// SPI mode-0 frame engine: CSN/SCLK/SDI generation for one 16-bit write, MSB first.
// Latency: CSN low on the start edge, 1 + 32*SCLK_DIV cycles until CSN rises with done.
// Backpressure: start is ignored while busy; the caller only starts from idle.
module dac_spi_shifter
    import dac_spi_pkg::*;
#(
    parameter int SCLK_DIV = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               frame_end,
    output logic               done,
    output logic               dac_csn,
    output logic               dac_sclk,
    output logic               dac_sdi
);

    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_W);

    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    // Bits still to be sent after the MSB, which goes straight to SDI on load
    logic [FRAME_W-2:0] shreg;

    // Last clk cycle of the 16th high half: next edge drops SCLK and raises CSN
    assign frame_end = busy && dac_sclk && (div_cnt == '0) && (bit_cnt == BIT_W'(FRAME_W - 1));

    // SCLK divider, bit counter and pin drivers; SDI only moves on SCLK falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            done     <= 1'b0;
            dac_csn  <= 1'b1;
            dac_sclk <= 1'b0;
            dac_sdi  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy     <= 1'b1;
                shreg    <= frame[FRAME_W-2:0];
                dac_csn  <= 1'b0;
                dac_sclk <= 1'b0;
                dac_sdi  <= frame[FRAME_W-1];
                // The load cycle itself adds one clk of setup before the first low half
                div_cnt  <= DIV_W'(SCLK_DIV);
                bit_cnt  <= '0;
            end else if (busy) begin
                if (div_cnt != '0) begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end else begin
                    div_cnt <= DIV_W'(SCLK_DIV - 1);
                    if (!dac_sclk) begin
                        dac_sclk <= 1'b1;
                    end else if (frame_end) begin
                        busy     <= 1'b0;
                        dac_sclk <= 1'b0;
                        dac_csn  <= 1'b1;
                        dac_sdi  <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        dac_sclk <= 1'b0;
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        dac_sdi  <= shreg[FRAME_W-2];
                        shreg    <= {shreg[FRAME_W-3:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing one 12-bit SPI DAC between NREQ level-sensitive requesters.
// Latency: grant and CSN low one edge after arbitration in IDLE; 166 cycles grant-to-grant minimum.
// Backpressure: requesters hold req/data until their one-cycle grant; no arbitration outside IDLE.
// Optional: define DAC_SPI_LDAC_EN to add the dac_ldacn pulse output (needs CSN_GAP >= 3).
module dac_spi_arbiter
    import dac_spi_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SCLK_DIV = 5,
    parameter int CSN_GAP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data,
    input  logic [NREQ-1:0]        gain,
    input  logic [NREQ-1:0]        shutdown,
    output logic [NREQ-1:0]        grant,
    output logic                   done,
    output logic                   dac_csn,
    output logic                   dac_sclk,
    output logic                   dac_sdi,
`ifdef DAC_SPI_LDAC_EN
    output logic                   dac_ldacn,
`endif
    output logic                   led
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GAP_W = $clog2(CSN_GAP + 1);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
            $error("dac_spi_arbiter: NREQ must be in 2..8");
        end
        if (SCLK_DIV < 1 || CSN_GAP < 1) begin : g_timing_chk
            $error("dac_spi_arbiter: SCLK_DIV and CSN_GAP must be at least 1");
        end
    endgenerate

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  sel_data;
    logic [FRAME_W-1:0] frame;
    logic               start;
    logic               busy;
    logic               frame_end;

    // Pick the first requester at or after the pointer; scanning downwards lets the nearest win
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Winner's control word, latched by the shifter on the start edge
    always_comb begin
        sel_data = data[int'(win_idx)*DATA_W +: DATA_W];
        frame    = build_frame(sel_data, gain[win_idx], shutdown[win_idx]);
    end

    assign start = (state == IDLE) && win_vld && !busy;

    dac_spi_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame     (frame),
        .busy      (busy),
        .frame_end (frame_end),
        .done      (done),
        .dac_csn   (dac_csn),
        .dac_sclk  (dac_sclk),
        .dac_sdi   (dac_sdi)
    );

    // Frame sequencing: grant/pointer update in IDLE, wait for the shifter, then hold the CSN gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gap_cnt <= '0;
            grant   <= '0;
            led     <= 1'b0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        grant <= NREQ'(1) << win_idx;
                        ptr   <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                        led   <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (frame_end) begin
                        state   <= GAP;
                        gap_cnt <= GAP_W'(CSN_GAP - 1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        led   <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DAC_SPI_LDAC_EN
    generate
        if (CSN_GAP < 3) begin : g_ldac_gap_chk
            $error("dac_spi_arbiter: DAC_SPI_LDAC_EN needs CSN_GAP >= 3");
        end
    endgenerate

    // LDAC low for the first two GAP cycles after CSN has risen, so the DAC updates on this pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_ldacn <= 1'b1;
        end else begin
            dac_ldacn <= !((state == GAP) &&
                           ((gap_cnt == GAP_W'(CSN_GAP - 1)) || (gap_cnt == GAP_W'(CSN_GAP - 2))));
        end
    end
`endif

endmodule
